// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, odd parity, one stop bit. The received
// byte is held with its parity/framing status until the consumer acknowledges it.
module uart_rx #(
    parameter int CLK_FREQUENCY = 100_000_000,
    parameter int BAUD_RATE     = 19_200
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Sin,
    input  logic       ReceiveAck,
    output logic       Receive,
    output logic [7:0] Dout,
    output logic       parityErr,
    output logic       frameErr
);
    localparam int BIT_CYCLES  = CLK_FREQUENCY / BAUD_RATE;
    localparam int HALF_CYCLES = BIT_CYCLES / 2;
    localparam int TW          = $clog2(BIT_CYCLES);
    localparam logic [TW-1:0] BIT_LAST  = TW'(BIT_CYCLES - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(HALF_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, ACK} state_t;

    state_t        state, next;
    logic          sin_meta, sin_s;
    logic [TW-1:0] timer;
    logic [3:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic          tmr_clr, cnt_clr, shift_en, par_en, load, ack_clr;

    // Flops preset to idle-high so reset release never looks like a start edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sin_meta <= 1'b1;
            sin_s    <= 1'b1;
        end else begin
            sin_meta <= Sin;
            sin_s    <= sin_meta;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= next;
    end

    always_comb begin
        next     = state;
        tmr_clr  = 1'b0;
        cnt_clr  = 1'b0;
        shift_en = 1'b0;
        par_en   = 1'b0;
        load     = 1'b0;
        ack_clr  = 1'b0;
        case (state)
            IDLE: begin
                tmr_clr = 1'b1;
                if (!sin_s) next = START;
            end
            START: if (timer == HALF_LAST) begin
                tmr_clr = 1'b1;
                if (!sin_s) begin
                    next    = DATA;
                    cnt_clr = 1'b1;
                end else begin
                    next = IDLE;
                end
            end
            DATA: if (timer == BIT_LAST) begin
                tmr_clr  = 1'b1;
                shift_en = 1'b1;
                if (bit_cnt == 4'd7) next = PAR;
            end
            PAR: if (timer == BIT_LAST) begin
                tmr_clr = 1'b1;
                par_en  = 1'b1;
                next    = STOP;
            end
            STOP: if (timer == BIT_LAST) begin
                tmr_clr = 1'b1;
                load    = 1'b1;
                next    = ACK;
            end
            ACK: begin
                tmr_clr = 1'b1;
                if (ReceiveAck) begin
                    ack_clr = 1'b1;
                    next    = IDLE;
                end
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            timer     <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            Dout      <= '0;
            parityErr <= 1'b0;
            frameErr  <= 1'b0;
            Receive   <= 1'b0;
        end else begin
            timer <= tmr_clr ? '0 : timer + 1'b1;
            if (cnt_clr)                          bit_cnt <= '0;
            else if (shift_en && bit_cnt != 4'hF) bit_cnt <= bit_cnt + 1'b1;
            if (shift_en) shreg   <= {sin_s, shreg[7:1]};
            if (par_en)   par_bit <= sin_s;
            if (load) begin
                Dout      <= shreg;
                parityErr <= ~(^{shreg, par_bit});
                frameErr  <= ~sin_s;
                Receive   <= 1'b1;
            end else if (ack_clr) begin
                Receive <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit; frames are driven bit-aligned
// on Sin and every expectation is a hand-computed constant.
module tb_uart_rx;
    logic       CLK = 1'b0;
    logic       RST, Sin, ReceiveAck;
    logic       Receive;
    logic [7:0] Dout;
    logic       parityErr, frameErr;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int start_cycle = 0;
    int rise_cycle = 0;
    int rise_cnt = 0;
    int hi_cnt = 0;
    logic [7:0] rise_dout[$];
    logic rcv_prev = 1'b0;

    uart_rx #(.CLK_FREQUENCY(16), .BAUD_RATE(1)) dut (
        .CLK(CLK), .RST(RST), .Sin(Sin), .ReceiveAck(ReceiveAck),
        .Receive(Receive), .Dout(Dout), .parityErr(parityErr), .frameErr(frameErr)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cycle <= cycle + 1;

    // Track Receive pulses: rise count, high cycles, rise time and byte at each rise.
    always @(negedge CLK) begin
        if (Receive) hi_cnt <= hi_cnt + 1;
        if (Receive && !rcv_prev) begin
            rise_cnt   <= rise_cnt + 1;
            rise_cycle <= cycle;
            rise_dout.push_back(Dout);
        end
        rcv_prev <= Receive;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        Sin = b;
        repeat (16) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        @(negedge CLK);
        start_cycle = cycle;
        Sin = 1'b0;
        repeat (16) @(negedge CLK);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stop);
    endtask

    task automatic ack_pulse();
        ReceiveAck = 1'b1;
        @(negedge CLK);
        ReceiveAck = 1'b0;
    endtask

    int lat;
    int rc;

    initial begin
        RST = 1'b1; Sin = 1'b1; ReceiveAck = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_receive", Receive, 0);
        chk("reset_dout", Dout, 8'h00);
        chk("reset_parity", parityErr, 0);
        chk("reset_frame", frameErr, 0);
        RST = 1'b0;
        repeat (10) @(negedge CLK);

        // good frame 0x41
        send_frame(8'h41, 1'b1, 1'b1);
        Sin = 1'b1;
        lat = rise_cycle - start_cycle;
        chk("good_receive", Receive, 1);
        chk("good_dout", Dout, 8'h41);
        chk("good_parity", parityErr, 0);
        chk("good_frame", frameErr, 0);
        chk("good_latency", (lat >= 169 && lat <= 171), 1);
        repeat (20) @(negedge CLK);
        chk("good_hold", Receive, 1);
        ack_pulse();
        chk("good_ack_fall", Receive, 0);
        chk("good_dout_kept", Dout, 8'h41);
        repeat (10) @(negedge CLK);

        // parity error
        send_frame(8'h41, 1'b0, 1'b1);
        Sin = 1'b1;
        chk("perr_dout", Dout, 8'h41);
        chk("perr_parity", parityErr, 1);
        chk("perr_frame", frameErr, 0);
        ack_pulse();
        repeat (10) @(negedge CLK);

        // reset mid-frame: start + 3 data bits of 0x5A, then a 1-cycle reset
        rc = rise_cnt;
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        RST = 1'b1;
        #1;
        chk("rstmid_receive", Receive, 0);
        chk("rstmid_dout", Dout, 8'h00);
        chk("rstmid_parity", parityErr, 0);
        chk("rstmid_frame", frameErr, 0);
        @(negedge CLK);
        RST = 1'b0;
        Sin = 1'b1;
        repeat (200) @(negedge CLK);
        chk("rstmid_no_receive", rise_cnt - rc, 0);

        send_frame(8'h5A, 1'b1, 1'b1);
        Sin = 1'b1;
        chk("5a_receive", Receive, 1);
        chk("5a_dout", Dout, 8'h5A);
        chk("5a_parity", parityErr, 0);
        ack_pulse();
        repeat (10) @(negedge CLK);

        // glitch rejection
        rc = rise_cnt;
        Sin = 1'b0;
        repeat (4) @(negedge CLK);
        Sin = 1'b1;
        repeat (40) @(negedge CLK);
        chk("glitch_no_receive", rise_cnt - rc, 0);
        send_frame(8'hFF, 1'b1, 1'b1);
        Sin = 1'b1;
        lat = rise_cycle - start_cycle;
        chk("ff_dout", Dout, 8'hFF);
        chk("ff_parity", parityErr, 0);
        chk("ff_latency", (lat >= 169 && lat <= 171), 1);
        ack_pulse();
        repeat (10) @(negedge CLK);

        // framing error
        send_frame(8'h00, 1'b1, 1'b0);
        Sin = 1'b1;
        chk("ferr_receive", Receive, 1);
        chk("ferr_dout", Dout, 8'h00);
        chk("ferr_parity", parityErr, 0);
        chk("ferr_frame", frameErr, 1);
        repeat (5) @(negedge CLK);
        ack_pulse();
        repeat (10) @(negedge CLK);

        // back-to-back with ReceiveAck tied high
        rc = rise_cnt;
        hi_cnt = 0;
        rise_dout.delete();
        ReceiveAck = 1'b1;
        send_frame(8'h01, 1'b0, 1'b1);
        chk("b2b_hold_between", Dout, 8'h01);
        send_frame(8'h80, 1'b0, 1'b1);
        Sin = 1'b1;
        repeat (20) @(negedge CLK);
        ReceiveAck = 1'b0;
        chk("b2b_pulses", rise_cnt - rc, 2);
        chk("b2b_high_cycles", hi_cnt, 2);
        chk("b2b_first", (rise_dout.size() > 0) ? rise_dout[0] : 8'hxx, 8'h01);
        chk("b2b_second", (rise_dout.size() > 1) ? rise_dout[1] : 8'hxx, 8'h80);
        chk("b2b_final_dout", Dout, 8'h80);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
